spis: RTL and testbench

- Quad-SPI target (responder) that answers a flash-style initiator, i.e. the SPI master on the opposite end of the link.
- Decodes instruction, 24-bit address, dummy and data phases received on the SPI pins.
- Turns each data byte into a single-byte transaction on a simple valid/ready bus toward on-chip memory.
- The SPI pins are oversampled in the clk domain; clk must be at least 8x the spi_ck frequency.

---
 rtl/spis.sv | 191 +++++++++++++++++++
 tb/tb_spis.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spis.sv
// rtl/spis.sv - Quad-SPI flash-style target turning SPI commands into single-byte bus transfers
module spis #(
    parameter int unsigned DUMMY_Q   = 8,
    parameter logic [7:0]  STATUS_ID = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs,
    input  logic        spi_ck,
    input  logic [3:0]  spi_di,
    output logic [3:0]  spi_do,
    output logic [3:0]  spi_oe,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_write,
    output logic [23:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        err_underrun,
    output logic        err_overrun
);
    typedef enum logic [3:0] {
        S_IDLE, S_INST, S_ADDR, S_DUMMY, S_WDATA, S_RDATA1, S_RDATA4, S_STAT, S_IGNORE
    } state_t;

    state_t      state;
    logic [1:0]  cs_s, ck_s, di_s;
    logic        ck_d;
    logic [4:0]  bitcnt;
    logic [2:0]  fcnt;
    logic [7:0]  sh, cmd, out_sh, pf_data, nb, rx_byte;
    logic [23:0] addr_r;
    logic        pf_valid, rd_want, rd_live, err_sticky, stat_err;
    logic        cs_hi, rise, fall, di0, rd_state, load;
    logic        unused_di;

    assign cs_hi     = cs_s[1];
    assign rise      = ck_s[1] & ~ck_d;
    assign fall      = ~ck_s[1] & ck_d;
    assign di0       = di_s[1];
    assign rx_byte   = {sh[6:0], di0};
    assign unused_di = ^spi_di[3:1];
    assign rd_state  = (state == S_RDATA1) || (state == S_RDATA4) || (state == S_STAT);
    assign load      = rd_state && fall && (fcnt == 3'd0) && !cs_hi;

    // Byte presented at the first fall of each output byte
    always_comb begin
        nb = 8'hFF;
        if (state == S_STAT)
            nb = {STATUS_ID[7:2], stat_err, bus_valid};
        else if (pf_valid)
            nb = pf_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cs_s <= 2'b11; ck_s <= 2'b00; di_s <= 2'b00; ck_d <= 1'b0;
            bitcnt <= '0; fcnt <= '0; sh <= '0; cmd <= '0; out_sh <= '0;
            pf_data <= '0; addr_r <= '0;
            pf_valid <= 1'b0; rd_want <= 1'b0; rd_live <= 1'b0;
            err_sticky <= 1'b0; stat_err <= 1'b0;
            spi_do <= '0; spi_oe <= '0;
            bus_valid <= 1'b0; bus_write <= 1'b0; bus_addr <= '0; bus_wdata <= '0;
            err_underrun <= 1'b0; err_overrun <= 1'b0;
        end else begin
            cs_s <= {cs_s[0], spi_cs};
            ck_s <= {ck_s[0], spi_ck};
            di_s <= {di_s[0], spi_di[0]};
            ck_d <= ck_s[1];
            err_underrun <= 1'b0;
            err_overrun  <= 1'b0;

            // A request always completes, but its read data is kept only for the live prefetch
            if (bus_valid && bus_ready) begin
                bus_valid <= 1'b0;
                if (!bus_write && rd_live) begin
                    pf_valid <= 1'b1;
                    pf_data  <= bus_rdata;
                end
            end

            if (cs_hi) begin
                state <= S_IDLE;
                spi_oe <= '0; spi_do <= '0;
                bitcnt <= '0; fcnt <= '0;
                rd_want <= 1'b0; rd_live <= 1'b0; pf_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state  <= S_INST;
                        bitcnt <= '0;
                    end
                    S_INST: if (rise) begin
                        sh     <= rx_byte;
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == 5'd7) begin
                            bitcnt <= '0;
                            fcnt   <= '0;
                            cmd    <= rx_byte;
                            case (rx_byte)
                                8'h02, 8'h03, 8'h6B: state <= S_ADDR;
                                8'h05: begin
                                    state      <= S_STAT;
                                    stat_err   <= err_sticky;
                                    err_sticky <= 1'b0;
                                end
                                default: state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (rise) begin
                        addr_r <= {addr_r[22:0], di0};
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == 5'd23) begin
                            bitcnt <= '0;
                            case (cmd)
                                8'h02:   state <= S_WDATA;
                                8'h03: begin state <= S_RDATA1; rd_want <= 1'b1; end
                                default: begin state <= S_DUMMY; rd_want <= 1'b1; end
                            endcase
                        end
                    end
                    S_DUMMY: if (rise) begin
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == 5'(DUMMY_Q - 1)) begin
                            bitcnt <= '0;
                            state  <= S_RDATA4;
                        end
                    end
                    S_WDATA: if (rise) begin
                        sh     <= rx_byte;
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == 5'd7) begin
                            bitcnt <= '0;
                            addr_r <= addr_r + 24'd1;
                            if (!bus_valid) begin
                                bus_valid <= 1'b1;
                                bus_write <= 1'b1;
                                bus_addr  <= addr_r;
                                bus_wdata <= rx_byte;
                            end else begin
                                err_overrun <= 1'b1;
                                err_sticky  <= 1'b1;
                            end
                        end
                    end
                    S_RDATA1, S_RDATA4, S_STAT: if (fall) begin
                        spi_oe <= (state == S_RDATA4) ? 4'b1111 : 4'b0010;
                        fcnt   <= (state == S_RDATA4) ? {2'b00, ~fcnt[0]} : fcnt + 3'd1;
                        if (load) begin
                            if (state == S_RDATA4) begin
                                spi_do <= nb[7:4];
                                out_sh <= {nb[3:0], 4'b0000};
                            end else begin
                                spi_do <= {2'b00, nb[7], 1'b0};
                                out_sh <= {nb[6:0], 1'b0};
                            end
                            if (state != S_STAT) begin
                                if (!pf_valid) begin
                                    err_underrun <= 1'b1;
                                    err_sticky   <= 1'b1;
                                end
                                // Any read still in flight is for a byte already given away
                                pf_valid <= 1'b0;
                                rd_live  <= 1'b0;
                                rd_want  <= 1'b1;
                                addr_r   <= addr_r + 24'd1;
                            end
                        end else if (state == S_RDATA4) begin
                            spi_do <= out_sh[7:4];
                            out_sh <= {out_sh[3:0], 4'b0000};
                        end else begin
                            spi_do <= {2'b00, out_sh[7], 1'b0};
                            out_sh <= {out_sh[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase

                if (rd_want && !bus_valid && !load) begin
                    bus_valid <= 1'b1;
                    bus_write <= 1'b0;
                    bus_addr  <= addr_r;
                    rd_want   <= 1'b0;
                    rd_live   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spis.sv
// tb/tb_spis.sv - self-checking bench for the spis quad-SPI target
module tb_spis;
    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs = 1'b1;
    logic        spi_ck = 1'b0;
    logic [3:0]  spi_di = 4'h0;
    logic [3:0]  spi_do, spi_oe;
    logic        bus_valid, bus_ready, bus_write;
    logic [23:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        err_underrun, err_overrun;

    typedef struct packed {
        logic        write;
        logic [23:0] addr;
        logic [7:0]  data;
    } txn_t;

    txn_t       exp_q[$];
    logic [7:0] mem [logic [23:0]];
    int         checks = 0;
    int         errors = 0;
    int         un_cnt = 0;
    int         ov_cnt = 0;
    bit         ready_en = 1'b1;

    spis #(.DUMMY_Q(8), .STATUS_ID(8'h00)) dut (
        .clk(clk), .rst(rst),
        .spi_cs(spi_cs), .spi_ck(spi_ck), .spi_di(spi_di),
        .spi_do(spi_do), .spi_oe(spi_oe),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .err_underrun(err_underrun), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        bus_ready = 1'b0;
        bus_rdata = 8'h00;
    end

    // Memory responder: one-cycle ready, and every accepted request is checked against the scoreboard
    always @(negedge clk) begin
        if (!rst && ready_en && bus_valid && !bus_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_txn: got write=%0b addr=%06h data=%02h, expected no request",
                         bus_write, bus_addr, bus_wdata);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                if (bus_write !== e.write || bus_addr !== e.addr || (e.write && bus_wdata !== e.data)) begin
                    errors++;
                    $display("FAIL bus_txn: got write=%0b addr=%06h data=%02h, expected write=%0b addr=%06h data=%02h",
                             bus_write, bus_addr, bus_wdata, e.write, e.addr, e.data);
                end
            end
            bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 8'h00;
            bus_ready = 1'b1;
        end else begin
            bus_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (err_underrun === 1'b1) un_cnt++;
        if (err_overrun === 1'b1) ov_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic w, input logic [23:0] a, input logic [7:0] d);
        txn_t t;
        t.write = w; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic spi_cycle(input logic [3:0] dout, input bit do_fall,
                             output logic [3:0] din, output logic [3:0] oe);
        spi_di = dout;
        repeat (HALF) @(negedge clk);
        din = spi_do;
        oe  = spi_oe;
        spi_ck = 1'b1;
        repeat (HALF) @(negedge clk);
        if (do_fall) spi_ck = 1'b0;
    endtask

    task automatic spi_start();
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_stop(input bit ck_high);
        if (ck_high) begin
            spi_cs = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_ck = 1'b0;
        end else begin
            spi_cs = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] d, o;
        for (int i = 7; i >= 0; i--) spi_cycle({3'b000, b[i]}, 1'b1, d, o);
    endtask

    // Clocks n cycles, collecting do[1] (single) or do[3:0] (quad) before each rise
    task automatic rx_cycles(input int n, input bit quad, input bit end_high, input logic [3:0] exp_oe,
                             output logic [31:0] data, output bit oe_bad);
        logic [3:0] d, o;
        data = '0;
        oe_bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_cycle(4'h0, !(end_high && i == n - 1), d, o);
            data = quad ? {data[27:0], d} : {data[30:0], d[1]};
            if (o !== exp_oe) oe_bad = 1'b1;
        end
    endtask

    task automatic wait_q_empty(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_bus_done: %0d requests still outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({spi_do, spi_oe, bus_valid, bus_write, bus_addr, bus_wdata, err_underrun, err_overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: do=%h oe=%h valid=%b write=%b addr=%h wdata=%h un=%b ov=%b, required all 0",
                     spi_do, spi_oe, bus_valid, bus_write, bus_addr, bus_wdata, err_underrun, err_overrun);
        end
    endtask

    task automatic test_write();
        ready_en = 1'b1; un_cnt = 0; ov_cnt = 0;
        push(1'b1, 24'h001000, 8'hA5);
        push(1'b1, 24'h001001, 8'h5A);
        spi_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h5A);
        spi_stop(1'b0);
        wait_q_empty("write");
        checks++;
        if (un_cnt != 0 || ov_cnt != 0) begin
            errors++;
            $display("FAIL write_errs: underrun=%0d overrun=%0d, required 0 0", un_cnt, ov_cnt);
        end
    endtask

    task automatic test_single_read();
        logic [31:0] d;
        bit bad;
        ready_en = 1'b1; un_cnt = 0;
        mem[24'h001000] = 8'hA5; mem[24'h001001] = 8'h5A; mem[24'h001002] = 8'hE7;
        push(1'b0, 24'h001000, 8'h00);
        push(1'b0, 24'h001001, 8'h00);
        push(1'b0, 24'h001002, 8'h00);
        spi_start();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        rx_cycles(16, 1'b0, 1'b1, 4'b0010, d, bad);
        spi_stop(1'b1);
        checks++;
        if (d[15:0] !== 16'hA55A) begin
            errors++;
            $display("FAIL read1_data: got %04h, required a55a", d[15:0]);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL read1_oe: oe not 0010 during data, required 0010");
        end
        wait_q_empty("read1");
        checks++;
        if (un_cnt != 0) begin
            errors++;
            $display("FAIL read1_underrun: got %0d pulses, required 0", un_cnt);
        end
    endtask

    task automatic test_quad_read();
        logic [31:0] d;
        bit bad;
        ready_en = 1'b1;
        mem[24'hFFFFFF] = 8'h3C; mem[24'h000000] = 8'hC3; mem[24'h000001] = 8'h5A;
        push(1'b0, 24'hFFFFFF, 8'h00);
        push(1'b0, 24'h000000, 8'h00);
        push(1'b0, 24'h000001, 8'h00);
        spi_start();
        send_byte(8'h6B); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        rx_cycles(8, 1'b1, 1'b0, 4'b0000, d, bad);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL quad_dummy_oe: oe enabled during dummy, required 0000");
        end
        rx_cycles(4, 1'b1, 1'b1, 4'b1111, d, bad);
        spi_stop(1'b1);
        checks++;
        if (d[15:0] !== 16'h3CC3) begin
            errors++;
            $display("FAIL quad_data: got nibbles %04h, required 3cc3", d[15:0]);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL quad_oe: oe not 1111 during data, required 1111");
        end
        wait_q_empty("quad");
    endtask

    task automatic test_underrun();
        logic [31:0] d;
        bit bad;
        ready_en = 1'b0; un_cnt = 0;
        mem[24'h002000] = 8'h77;
        push(1'b0, 24'h002000, 8'h00);
        spi_start();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
        rx_cycles(8, 1'b0, 1'b1, 4'b0010, d, bad);
        spi_stop(1'b1);
        checks++;
        if (d[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL underrun_data: got %02h, required ff", d[7:0]);
        end
        checks++;
        if (un_cnt != 1) begin
            errors++;
            $display("FAIL underrun_pulse: got %0d pulses, required 1", un_cnt);
        end
        repeat (64) @(negedge clk);
        checks++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 24'h002000) begin
            errors++;
            $display("FAIL underrun_hold: valid=%b write=%b addr=%06h, required 1 0 002000",
                     bus_valid, bus_write, bus_addr);
        end
        ready_en = 1'b1;
        wait_q_empty("underrun");
        spi_start();
        send_byte(8'h05);
        rx_cycles(8, 1'b0, 1'b0, 4'b0010, d, bad);
        spi_stop(1'b0);
        checks++;
        if (d[7:0] !== 8'h02) begin
            errors++;
            $display("FAIL stat_sticky: got %02h, required 02", d[7:0]);
        end
        spi_start();
        send_byte(8'h05);
        rx_cycles(8, 1'b0, 1'b0, 4'b0010, d, bad);
        spi_stop(1'b0);
        checks++;
        if (d[7:0] !== 8'h00) begin
            errors++;
            $display("FAIL stat_cleared: got %02h, required 00", d[7:0]);
        end
    endtask

    task automatic test_overrun_abort();
        logic [3:0] d, o;
        ready_en = 1'b0; un_cnt = 0; ov_cnt = 0;
        push(1'b1, 24'h003000, 8'h11);
        spi_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h30); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        for (int i = 0; i < 4; i++) spi_cycle({3'b000, i[0]}, 1'b1, d, o);
        spi_stop(1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (spi_oe !== 4'h0 || spi_do !== 4'h0) begin
            errors++;
            $display("FAIL abort_pins: oe=%h do=%h, required 0 0", spi_oe, spi_do);
        end
        checks++;
        if (bus_valid !== 1'b1 || bus_write !== 1'b1 || bus_addr !== 24'h003000 || bus_wdata !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold: valid=%b write=%b addr=%06h wdata=%02h, required 1 1 003000 11",
                     bus_valid, bus_write, bus_addr, bus_wdata);
        end
        checks++;
        if (ov_cnt != 2) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d, required 2", ov_cnt);
        end
        ready_en = 1'b1;
        wait_q_empty("overrun");
        repeat (20) @(negedge clk);
        checks++;
        if (bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write: bus_valid=%b, required 0", bus_valid);
        end
    endtask

    task automatic test_unknown_cmd();
        logic [3:0] d, o;
        logic [31:0] rd;
        bit bad, bad2;
        logic [7:0] c;
        ready_en = 1'b1;
        bad = 1'b0;
        c = 8'h9F;
        spi_start();
        for (int i = 7; i >= 0; i--) begin
            spi_cycle({3'b000, c[i]}, 1'b1, d, o);
            if (o !== 4'h0) bad = 1'b1;
        end
        rx_cycles(8, 1'b0, 1'b0, 4'b0000, rd, bad2);
        spi_stop(1'b0);
        checks++;
        if (bad || bad2) begin
            errors++;
            $display("FAIL ignore_oe: oe enabled during 9f, required 0000");
        end
        checks++;
        if (bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_bus: bus_valid=%b, required 0", bus_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        bit bad;
        ready_en = 1'b1;
        mem[24'h004000] = 8'hC3; mem[24'h004001] = 8'h3C;
        push(1'b0, 24'h004000, 8'h00);
        push(1'b0, 24'h004001, 8'h00);
        spi_start();
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00);
        rx_cycles(3, 1'b0, 1'b0, 4'b0010, d, bad);
        checks++;
        if (bad || d[2:0] !== 3'b110) begin
            errors++;
            $display("FAIL rst_pre_read: bits=%b oe_bad=%b, required 110 0", d[2:0], bad);
        end
        wait_q_empty("rst_read");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        spi_cs = 1'b1;
        spi_ck = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        test_write();
        test_single_read();
        test_quad_read();
        test_underrun();
        test_overrun_abort();
        test_unknown_cmd();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
